// File: rtl/stream_demux_pkg.sv
// Shared types for stream_demux: drop counter width/type and its saturating increment.
package stream_demux_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    localparam drop_cnt_t DROP_CNT_MAX = '1;

    function automatic drop_cnt_t drop_cnt_sat_inc(input drop_cnt_t cnt);
        return (cnt == DROP_CNT_MAX) ? cnt : cnt + drop_cnt_t'(1);
    endfunction

endpackage

// File: rtl/stream_demux_fifo2.sv
// Two-entry per-channel FIFO: head register feeds the output directly, tail holds the second word.
module stream_demux_fifo2 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int unsigned CNT_W = 2;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok;
    logic              pop_ok;

    // Next-state: pushes into a full buffer and pops from an empty one are ignored.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        push_ok = push_i & ~full_q;
        pop_ok  = pop_i & ~empty_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (empty_q) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - CNT_W'(1);
            end
            2'b11: begin
                // Only reachable with one word held: new word becomes the head, count unchanged.
                head_d = data_i;
            end
            default: begin
            end
        endcase
        full_d  = (count_d == CNT_W'(2));
        empty_d = (count_d == CNT_W'(0));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign head_o  = head_q;

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready stream to OUT_CNT buffered output streams by sel_i; out-of-range words are
// accepted, discarded and counted.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned  OUT_CNT = 2,
    parameter int unsigned  DATA_W  = 8,
    localparam int unsigned SEL_W   = (OUT_CNT > 1) ? $clog2(OUT_CNT) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [DATA_W-1:0]              data_i,
    input  logic [SEL_W-1:0]               sel_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic [OUT_CNT-1:0][DATA_W-1:0] data_o,
    output logic [OUT_CNT-1:0]             valid_o,
    input  logic [OUT_CNT-1:0]             ready_i,
    output logic                           drop_o,
    output drop_cnt_t                      drop_cnt_o
);

    localparam logic [SEL_W:0] OUT_CNT_X = (SEL_W + 1)'(OUT_CNT);

    logic [OUT_CNT-1:0] full;
    logic [OUT_CNT-1:0] empty;
    logic [OUT_CNT-1:0] push;
    logic [OUT_CNT-1:0] pop;
    logic               sel_oor;
    logic               ready_c;
    logic               fire_in;
    logic               drop_q;
    drop_cnt_t          drop_cnt_q;

    // Ready depends only on sel_i and registered fill state, never on ready_i.
    always_comb begin
        sel_oor = ({1'b0, sel_i} >= OUT_CNT_X);
        ready_c = sel_oor;
        push    = '0;
        for (int k = 0; k < int'(OUT_CNT); k++) begin
            if (sel_i == SEL_W'(k)) begin
                ready_c = ~full[k];
            end
        end
        fire_in = valid_i & ready_c;
        for (int k = 0; k < int'(OUT_CNT); k++) begin
            push[k] = fire_in & (sel_i == SEL_W'(k));
        end
    end

    assign valid_o = ~empty;
    assign pop     = valid_o & ready_i;
    assign ready_o = ready_c;

    for (genvar k = 0; k < OUT_CNT; k++) begin : g_ch
        stream_demux_fifo2 #(
            .DATA_W(DATA_W)
        ) u_fifo (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .push_i (push[k]),
            .data_i (data_i),
            .pop_i  (pop[k]),
            .full_o (full[k]),
            .empty_o(empty[k]),
            .head_o (data_o[k])
        );
    end

    // Drop pulse and saturating counter for accepted out-of-range words.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_q <= fire_in & sel_oor;
            if (fire_in && sel_oor) begin
                drop_cnt_q <= drop_cnt_sat_inc(drop_cnt_q);
            end
        end
    end

    assign drop_o     = drop_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 2-channel instance for routing/backpressure/reset and a
// 3-channel instance for out-of-range drops and counter saturation.
module tb_stream_demux;

    logic clk_i = 1'b0;
    logic rst_n_i;

    always #5 clk_i = ~clk_i;

    // 2-channel instance
    logic [7:0]      d2_data_i;
    logic [0:0]      d2_sel_i;
    logic            d2_valid_i;
    logic            d2_ready_o;
    logic [1:0][7:0] d2_data_o;
    logic [1:0]      d2_valid_o;
    logic [1:0]      d2_ready_i;
    logic            d2_drop_o;
    logic [15:0]     d2_drop_cnt_o;

    // 3-channel instance
    logic [7:0]      d3_data_i;
    logic [1:0]      d3_sel_i;
    logic            d3_valid_i;
    logic            d3_ready_o;
    logic [2:0][7:0] d3_data_o;
    logic [2:0]      d3_valid_o;
    logic [2:0]      d3_ready_i;
    logic            d3_drop_o;
    logic [15:0]     d3_drop_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    stream_demux #(.OUT_CNT(2), .DATA_W(8)) dut2 (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .data_i    (d2_data_i),
        .sel_i     (d2_sel_i),
        .valid_i   (d2_valid_i),
        .ready_o   (d2_ready_o),
        .data_o    (d2_data_o),
        .valid_o   (d2_valid_o),
        .ready_i   (d2_ready_i),
        .drop_o    (d2_drop_o),
        .drop_cnt_o(d2_drop_cnt_o)
    );

    stream_demux #(.OUT_CNT(3), .DATA_W(8)) dut3 (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .data_i    (d3_data_i),
        .sel_i     (d3_sel_i),
        .valid_i   (d3_valid_i),
        .ready_o   (d3_ready_o),
        .data_o    (d3_data_o),
        .valid_o   (d3_valid_o),
        .ready_i   (d3_ready_i),
        .drop_o    (d3_drop_o),
        .drop_cnt_o(d3_drop_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send2(input logic [7:0] data, input logic sel);
        d2_data_i  = data;
        d2_sel_i   = sel;
        d2_valid_i = 1'b1;
    endtask

    initial begin
        rst_n_i    = 1'b0;
        d2_data_i  = 8'h77;
        d2_sel_i   = 1'b0;
        d2_valid_i = 1'b1;
        d2_ready_i = 2'b00;
        d3_data_i  = 8'h00;
        d3_sel_i   = 2'd0;
        d3_valid_i = 1'b0;
        d3_ready_i = 3'b111;

        // 1. Reset with valid_i held high
        step();
        step();
        check_eq("rst_valid_o", 32'(d2_valid_o), 32'h0);
        check_eq("rst_data_o", 32'(d2_data_o), 32'h0);
        check_eq("rst_drop_o", 32'(d2_drop_o), 32'h0);
        d2_valid_i = 1'b0;
        rst_n_i    = 1'b1;
        step();
        check_eq("rst_rel_valid_o", 32'(d2_valid_o), 32'h0);
        check_eq("rst_rel_drop_cnt", 32'(d2_drop_cnt_o), 32'h0);
        check_eq("rst_rel_d3_cnt", 32'(d3_drop_cnt_o), 32'h0);

        // 2. Streaming, alternating channels, both consumers ready
        d2_ready_i = 2'b11;
        for (int i = 0; i < 16; i++) begin
            send2(8'(8'h10 + i), 1'(i % 2));
            #1;
            check_eq("stream_ready_o", 32'(d2_ready_o), 32'h1);
            step();
            check_eq("stream_valid_o", 32'(d2_valid_o), 32'(2'b01 << (i % 2)));
            check_eq("stream_data_o", 32'(d2_data_o[i % 2]), 32'(8'h10 + i));
        end
        d2_valid_i = 1'b0;
        step();
        check_eq("stream_drain", 32'(d2_valid_o), 32'h0);

        // 3. Backpressure on ch0, ch1 keeps flowing
        d2_ready_i = 2'b10;
        send2(8'hA1, 1'b0);
        step();
        check_eq("bp_a1_valid", 32'(d2_valid_o), 32'h1);
        send2(8'hB1, 1'b1);
        step();
        check_eq("bp_b1_data", 32'(d2_data_o[1]), 32'hB1);
        check_eq("bp_b1_valid", 32'(d2_valid_o), 32'h3);
        send2(8'hA2, 1'b0);
        #1;
        check_eq("bp_a2_ready", 32'(d2_ready_o), 32'h1);
        step();
        check_eq("bp_a2_valid", 32'(d2_valid_o), 32'h1);
        send2(8'hB2, 1'b1);
        #1;
        check_eq("bp_b2_ready", 32'(d2_ready_o), 32'h1);
        step();
        check_eq("bp_b2_data", 32'(d2_data_o[1]), 32'hB2);
        check_eq("bp_b2_valid", 32'(d2_valid_o), 32'h3);
        send2(8'hA3, 1'b0);
        #1;
        check_eq("bp_a3_stall", 32'(d2_ready_o), 32'h0);
        step();
        check_eq("bp_head_a1", 32'(d2_data_o[0]), 32'hA1);
        check_eq("bp_ch1_empty", 32'(d2_valid_o), 32'h1);
        d2_ready_i = 2'b11;
        #1;
        check_eq("bp_rel_ready", 32'(d2_ready_o), 32'h0);
        step();
        check_eq("bp_head_a2", 32'(d2_data_o[0]), 32'hA2);
        check_eq("bp_a3_accept", 32'(d2_ready_o), 32'h1);
        step();
        check_eq("bp_head_a3", 32'(d2_data_o[0]), 32'hA3);
        check_eq("bp_a3_valid", 32'(d2_valid_o), 32'h1);
        d2_valid_i = 1'b0;
        step();
        check_eq("bp_drain", 32'(d2_valid_o), 32'h0);

        // 4. Simultaneous push and pop with one word held
        d2_ready_i = 2'b00;
        send2(8'h55, 1'b0);
        step();
        check_eq("pp_head_55", 32'(d2_data_o[0]), 32'h55);
        d2_ready_i = 2'b01;
        send2(8'h66, 1'b0);
        #1;
        check_eq("pp_ready", 32'(d2_ready_o), 32'h1);
        step();
        check_eq("pp_head_66", 32'(d2_data_o[0]), 32'h66);
        check_eq("pp_valid", 32'(d2_valid_o), 32'h1);
        d2_valid_i = 1'b0;
        step();
        check_eq("pp_no_dup", 32'(d2_valid_o), 32'h0);

        // 6. Reset mid-operation: ch0 full, ch1 holding one word
        d2_ready_i = 2'b00;
        send2(8'hC1, 1'b0);
        step();
        send2(8'hC2, 1'b0);
        step();
        send2(8'hD1, 1'b1);
        step();
        check_eq("mid_pre_valid", 32'(d2_valid_o), 32'h3);
        d2_valid_i = 1'b0;
        rst_n_i    = 1'b0;
        step();
        rst_n_i = 1'b1;
        check_eq("mid_rst_valid", 32'(d2_valid_o), 32'h0);
        check_eq("mid_rst_data", 32'(d2_data_o), 32'h0);
        d2_ready_i = 2'b11;
        send2(8'hE1, 1'b1);
        #1;
        check_eq("mid_ready", 32'(d2_ready_o), 32'h1);
        step();
        check_eq("mid_after_valid", 32'(d2_valid_o), 32'h2);
        check_eq("mid_after_data", 32'(d2_data_o[1]), 32'hE1);
        d2_valid_i = 1'b0;
        step();

        // 5. Out-of-range select on the 3-channel instance
        d3_ready_i = 3'b111;
        d3_sel_i   = 2'd3;
        d3_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d3_data_i = 8'(8'hD0 + i);
            #1;
            check_eq("drop_ready", 32'(d3_ready_o), 32'h1);
            step();
            check_eq("drop_pulse", 32'(d3_drop_o), 32'h1);
            check_eq("drop_no_valid", 32'(d3_valid_o), 32'h0);
        end
        d3_valid_i = 1'b0;
        step();
        check_eq("drop_pulse_end", 32'(d3_drop_o), 32'h0);
        check_eq("drop_cnt_4", 32'(d3_drop_cnt_o), 32'h4);
        d3_valid_i = 1'b1;
        for (int i = 0; i < 65530; i++) begin
            step();
        end
        d3_valid_i = 1'b0;
        step();
        check_eq("drop_cnt_fffe", 32'(d3_drop_cnt_o), 32'hFFFE);
        d3_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        d3_valid_i = 1'b0;
        step();
        check_eq("drop_cnt_sat", 32'(d3_drop_cnt_o), 32'hFFFF);
        d3_data_i  = 8'h9C;
        d3_sel_i   = 2'd2;
        d3_valid_i = 1'b1;
        step();
        d3_valid_i = 1'b0;
        check_eq("ch2_valid", 32'(d3_valid_o), 32'h4);
        check_eq("ch2_data", 32'(d3_data_o[2]), 32'h9C);
        check_eq("ch2_no_drop", 32'(d3_drop_o), 32'h0);
        check_eq("ch2_cnt_hold", 32'(d3_drop_cnt_o), 32'hFFFF);
        check_eq("d2_cnt_zero", 32'(d2_drop_cnt_o), 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
